key_seg_disp: RTL and testbench
===============================

# key_seg_disp

Downstream display stage for the keypad path. Consumes one-cycle key events (5-bit key code plus valid strobe) from the matrix scanner, edits a 4-digit hex entry buffer (shift-in, backspace, clear, blank), and drives a time-multiplexed common-anode 7-segment display. It also exposes the assembled 16-bit value for downstream logic.

## Interface
- `CLK_HZ`, 10_000_000: system clock frequency.
- `REFRESH_HZ`, 1000: full-display refresh rate. Per-digit dwell is `CLK_HZ/(REFRESH_HZ*4)` cycles, 2500 at the defaults.
- `i_clk`  in  1: system clock. One clock domain only.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_key_valid`  in  1: one-cycle strobe; `i_key_code` is valid on this cycle.
- `i_key_code`  in  5: key code (see Operation).
- `o_seg_d`  out  8: segments `{dp,g,f,e,d,c,b,a}`, active-low, registered.
- `o_seg_com`  out  4: digit enables, active-low, one-hot-low, registered. Bit 0 is the rightmost digit.
- `o_value`  out  16: buffer contents `{d3,d2,d1,d0}`, registered.
- `o_count`  out  3: number of entered digits, 0..4.
- `o_blank`  out  1: display-blank flag.

## Operation
- **Key codes:**
  - 0: none.
  - 1–16: hex digit `code-1`.
  - 17: backspace.
  - 18: clear.
  - 19: blank toggle.
  - 20–31: ignored.
- **Digit entry:** `d3..d0 <= {d2,d1,d0,code-1}`. `o_count` increments and saturates at 4. At 4, d3 is discarded.
- **Backspace:** `d <= {4'h0,d3,d2,d1}`. `o_count` decrements. On empty it is a no-op.
- **Clear:** digits are zeroed, `o_count=0`, and `o_blank` is unchanged.
- **Blank toggle:** `o_blank <= ~o_blank`. The buffer is untouched.
- A `i_key_code` with `i_key_valid=0` is ignored. Only one event is processed per valid cycle; back-to-back valid cycles are each processed.
- **Scan:**
  - A prescaler counts 0..DWELL-1. At the terminal count it emits `tick`.
  - On `tick`, a 2-bit digit index advances 0→1→2→3→0.
- **Per-digit output:**
  - `o_seg_com` is low on the current index only.
  - `o_seg_d` is the hex decode of that digit.
  - The digit is forced to all-off (`8'hFF`) if its index ≥ `o_count`, or if `o_blank=1`.
  - With `o_count=0`, digit 0 shows `0`; this is the only exception to the rule above.
  - `dp` is always off (1).
- **Decode (active-low `gfedcba`):** 0=`1000000`, 1=`1111001`, 2=`0100100`, 3=`0110000`, 4=`0011001`, 5=`0010010`, 6=`0000010`, 7=`1111000`, 8=`0000000`, 9=`0010000`, A=`0001000`, b=`0000011`, C=`1000110`, d=`0100001`, E=`0000110`, F=`0001110`.

## Timing
- **Reset values** (on the first `i_clk` edge with `i_rst=1`):
  - digits 0, `o_count=0`, `o_value=0`, `o_blank=0`;
  - prescaler 0, index 0;
  - `o_seg_com=4'b1110`, `o_seg_d=8'hC0` (digit 0 shows "0").
- **Reset mid-operation:** everything returns to reset values at the next edge. A key valid in the same cycle as reset is dropped.
- **Key latency:** the valid on cycle N updates `o_value`, `o_count` and `o_blank` at edge N+1. `o_seg_d` reflects the change at edge N+2 if the displayed index is affected.
- **Scan timing:**
  - `o_seg_com` changes only on the edge following `tick`. Each digit is held exactly DWELL cycles.
  - `o_seg_d` and `o_seg_com` update on the same edge, so there is no ghosting cycle.
- **Simultaneous key event and `tick`:** both take effect. The new index is decoded from the post-update buffer at the following edge, with no lost key and no skipped digit.
- **Prescaler width:** `$clog2(DWELL)`. The terminal compare uses DWELL-1. DWELL must be ≥ 2.

## Structure
- Package `key_seg_pkg`:
  - key-code constants `KEY_NONE`, `KEY_BKSP=17`, `KEY_CLR=18`, `KEY_BLANK=19`;
  - `SEG_OFF=8'hFF`;
  - the digit-count constant 4.
- Sub-module `hex7seg`: combinational 4-bit to active-low 7-bit decoder, instantiated once on the muxed digit.
- The top holds four blocks: the entry buffer/count logic, the prescaler plus index counter, the digit mux with blanking, and the output registers.

## Test plan
- **Reset, then idle.** Stimulus: reset, no keys. Required: `o_seg_com` cycles 1110→1101→1011→0111 every 2500 cycles. `o_seg_d` is `8'hC0` on digit 0 and `8'hFF` elsewhere. `o_value=0`.
- **Entry and overflow.** Stimulus: keys 2,3,4,5,6 (digits 1..5). Required: after the 4th key, `o_value=16'h1234`, `o_count=4`. After the 5th, `o_value=16'h2345`, `o_count=4`. The digit-3 segment pattern is `0100100` with dp off.
- **Backspace and clear.** Stimulus: from `16'h2345`, send 17 five times. Required: `o_value` goes 0234, 0023, 0002, 0000; `o_count` 3..0, then stays 0. Then keys 11,18. Required: `o_value=0`, `o_count=0`.
- **Blank toggle.** Stimulus: code 19. Required: `o_seg_d=8'hFF` on all digits for a full 4×2500-cycle scan. A second 19 restores the display. The buffer is unchanged throughout.
- **Ignored codes and simultaneous events.**
  - Codes 0, 20, 21 with valid: no state change.
  - A valid digit key on the same cycle as `tick`: key applied, index advances, and the next digit is decoded from the updated buffer.
- **Reset mid-scan.** Stimulus: assert `i_rst` during the digit-2 dwell with a valid key asserted. Required: reset values at the next edge and the key is dropped.

Source files
------------

// File: rtl/key_seg_disp_pkg.sv
// Shared key codes, segment constants and a digit-select helper for the keypad display stage.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package key_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_HEX_F = 5'd16;
  localparam logic [4:0] KEY_BKSP  = 5'd17;
  localparam logic [4:0] KEY_CLR   = 5'd18;
  localparam logic [4:0] KEY_BLANK = 5'd19;

  // Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_ZERO = 8'hC0;

  // Active-low one-hot common enable for a digit index (bit 0 = rightmost).
  function automatic logic [3:0] com_onehot_low(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/key_seg_disp_hex7seg.sv
// Hex nibble to active-low gfedcba segment decoder.
// Latency: purely combinational.
// Backpressure: none.
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Lookup of the active-low gfedcba pattern for each hex value.
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/key_seg_disp.sv
// Hex entry buffer edited by key events, driving a 4-digit multiplexed common-anode display.
// Latency: key to o_value/o_count/o_blank 1 cycle; to o_seg_d 2 cycles.
// Backpressure: none; every valid key event is consumed in the cycle it arrives.
module key_seg_disp
  import key_seg_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [4:0]  i_key_code,
  output logic [7:0]  o_seg_d,
  output logic [3:0]  o_seg_com,
  output logic [15:0] o_value,
  output logic [2:0]  o_count,
  output logic        o_blank
);

  localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW    = $clog2(DWELL);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          tick;
  logic          is_digit;
  logic [3:0]    key_digit;
  logic [3:0]    digit_sel;
  logic [6:0]    seg7;
  logic          show;
  logic [7:0]    seg_next;

  assign is_digit  = (i_key_code != KEY_NONE) && (i_key_code <= KEY_HEX_F);
  // Codes 1..16 map to 0..F; the 4-bit wrap takes 16 to F.
  assign key_digit = i_key_code[3:0] - 4'd1;

  // Entry buffer, digit count and blank flag updated from key events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_value <= '0;
      o_count <= '0;
      o_blank <= 1'b0;
    end else if (i_key_valid) begin
      if (is_digit) begin
        o_value <= {o_value[11:0], key_digit};
        if (o_count != 3'(NUM_DIGITS)) o_count <= o_count + 3'd1;
      end else if (i_key_code == KEY_BKSP) begin
        if (o_count != 3'd0) begin
          o_value <= {4'h0, o_value[15:4]};
          o_count <= o_count - 3'd1;
        end
      end else if (i_key_code == KEY_CLR) begin
        o_value <= '0;
        o_count <= '0;
      end else if (i_key_code == KEY_BLANK) begin
        o_blank <= ~o_blank;
      end
    end
  end

  assign tick = (presc == PW'(DWELL - 1));

  // Dwell prescaler and digit index; index steps once per dwell period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  hex7seg u_hex7seg (
    .hex (digit_sel),
    .seg (seg7)
  );

  // Digit mux with blanking; uses the upcoming index so segments and enables move together.
  always_comb begin
    idx_next  = tick ? idx + 2'd1 : idx;
    digit_sel = o_value[{idx_next, 2'b00} +: 4];
    show      = !o_blank &&
                (({1'b0, idx_next} < o_count) || (o_count == 3'd0 && idx_next == 2'd0));
    seg_next  = show ? {1'b1, seg7} : SEG_OFF;
  end

  // Registered segment and common drives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg_com <= 4'b1110;
      o_seg_d   <= SEG_ZERO;
    end else begin
      o_seg_com <= com_onehot_low(idx_next);
      o_seg_d   <= seg_next;
    end
  end

endmodule

// File: tb/tb_key_seg_disp.sv
module tb_key_seg_disp;

  localparam int DWELL = 2500;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_key_valid;
  logic [4:0]  i_key_code;
  logic [7:0]  o_seg_d;
  logic [3:0]  o_seg_com;
  logic [15:0] o_value;
  logic [2:0]  o_count;
  logic        o_blank;

  always #5 i_clk = ~i_clk;

  key_seg_disp #(.CLK_HZ(10_000_000), .REFRESH_HZ(1000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_key_valid (i_key_valid),
    .i_key_code  (i_key_code),
    .o_seg_d     (o_seg_d),
    .o_seg_com   (o_seg_com),
    .o_value     (o_value),
    .o_count     (o_count),
    .o_blank     (o_blank)
  );

  typedef struct {
    logic [7:0]  seg;
    logic [3:0]  com;
    logic [15:0] value;
    logic [2:0]  count;
    logic        blank;
    int          k;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state: entry value as an integer, digit count, blank flag, edges since reset.
  int m_value = 0;
  int m_count = 0;
  int m_blank = 0;
  int m_k = 0;
  bit started = 0;

  logic [6:0] dec_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [7:0] exp_seg(input int value, input int count,
                                         input int blank, input int idx);
    int d;
    d = (value >> (4 * idx)) & 15;
    if (blank != 0) return 8'hFF;
    if (idx < count || (count == 0 && idx == 0)) return {1'b1, dec_tbl[d]};
    return 8'hFF;
  endfunction

  // Model: at every edge predict the outputs and push them to the scoreboard.
  initial begin
    exp_t e;
    int idx;
    int c;
    logic [3:0] one;
    one = 4'b0001;
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        started = 1;
        m_value = 0; m_count = 0; m_blank = 0; m_k = 0;
        e.seg = 8'hC0;
        e.com = 4'b1110;
      end else if (started) begin
        m_k = m_k + 1;
        idx = (m_k / DWELL) % 4;
        e.seg = exp_seg(m_value, m_count, m_blank, idx);
        e.com = ~(one << idx);
        if (i_key_valid) begin
          c = int'(i_key_code);
          if (c >= 1 && c <= 16) begin
            m_value = (m_value * 16 + (c - 1)) % 65536;
            if (m_count < 4) m_count = m_count + 1;
          end else if (c == 17) begin
            if (m_count > 0) begin
              m_value = m_value / 16;
              m_count = m_count - 1;
            end
          end else if (c == 18) begin
            m_value = 0;
            m_count = 0;
          end else if (c == 19) begin
            m_blank = (m_blank == 0) ? 1 : 0;
          end
        end
      end
      e.value = 16'(m_value);
      e.count = 3'(m_count);
      e.blank = (m_blank != 0);
      e.k     = m_k;
      if (started) sb.push_back(e);
    end
  end

  task automatic check(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  // Monitor: outputs are registered every cycle, so one vector is checked per clock.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors = vectors + 1;
        check("seg_d", e.k, {8'h00, o_seg_d}, {8'h00, e.seg});
        check("seg_com", e.k, {12'h000, o_seg_com}, {12'h000, e.com});
        check("value", e.k, o_value, e.value);
        check("count", e.k, {13'h0, o_count}, {13'h0, e.count});
        check("blank", e.k, {15'h0, o_blank}, {15'h0, e.blank});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // One valid cycle, then the code bus carries junk with valid low.
  task automatic send(input int code);
    @(negedge i_clk);
    i_key_valid = 1'b1;
    i_key_code  = 5'(code);
    @(negedge i_clk);
    i_key_valid = 1'b0;
    i_key_code  = 5'($urandom);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_key_valid = 1'b1;
      i_key_code  = 5'($urandom_range(1, 19));
    end
    @(negedge i_clk);
    i_key_valid = 1'b0;
  endtask

  // Key sampled on the same edge as the index advance.
  task automatic send_at_tick(input int code);
    int guard;
    guard = 0;
    @(negedge i_clk);
    while ((m_k % DWELL) != DWELL - 1 && guard < 2 * DWELL) begin
      @(negedge i_clk);
      guard = guard + 1;
    end
    if (guard >= 2 * DWELL) begin
      miscompares = miscompares + 1;
      $display("FAIL tick_align timeout guard=%0d", guard);
    end
    i_key_valid = 1'b1;
    i_key_code  = 5'(code);
    @(negedge i_clk);
    i_key_valid = 1'b0;
  endtask

  int r;

  initial begin
    i_rst = 1'b1;
    i_key_valid = 1'b0;
    i_key_code = 5'd0;
    idle(2);
    i_rst = 1'b0;

    // Idle scan over more than one full refresh.
    idle(4 * DWELL + 100);

    // Entry with overflow, then backspace past empty, then digit and clear.
    for (int c = 2; c <= 6; c++) begin send(c); idle(3); end
    repeat (5) begin send(17); idle(2); end
    send(11); idle(2); send(18); idle(2);

    // Blank over a whole scan with a populated buffer, then restore.
    send(4); send(8); send(19);
    idle(4 * DWELL + 10);
    send(19); idle(20);

    // Ignored codes.
    send(0); send(20); send(21); send(31); idle(5);

    // Key on the tick edge, several times to land on different digits.
    send_at_tick(10);
    send_at_tick(13);
    send_at_tick(17);
    idle(5);

    // Randomised traffic including back-to-back valid cycles.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) send($urandom_range(1, 16));
      else if (r == 6) send($urandom_range(17, 19));
      else if (r == 7) send($urandom_range(0, 31));
      else burst($urandom_range(2, 5));
      idle($urandom_range(0, 6));
    end
    send_at_tick($urandom_range(1, 16));

    // Reset during the digit-2 dwell with a key on the same cycle.
    send(3); send(7); send(9);
    begin
      int guard;
      guard = 0;
      while (!(((m_k / DWELL) % 4) == 2 && (m_k % DWELL) == DWELL / 2) && guard < 5 * DWELL) begin
        @(negedge i_clk);
        guard = guard + 1;
      end
      if (guard >= 5 * DWELL) begin
        miscompares = miscompares + 1;
        $display("FAIL midscan_align timeout guard=%0d", guard);
      end
    end
    i_rst = 1'b1;
    i_key_valid = 1'b1;
    i_key_code = 5'd5;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_key_valid = 1'b0;
    idle(DWELL + 20);
    send(2); send(16); idle(10);

    @(negedge i_clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
